// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for an in-place radix-2 sequential FFT: bit-reversed load,
// per-stage butterfly read/write-back addressing with twiddle indices, then read-out.
module fft_seq_ctrl #(
  parameter int N      = 16,
  parameter int SIZE   = 4,
  parameter int WR_DLY = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            load_data,
  output logic [SIZE:0]   invert_adr,
  output logic            en_rd,
  output logic [SIZE:0]   rd_ptr,
  output logic            en_wr,
  output logic [SIZE:0]   wr_ptr,
  output logic [SIZE-2:0] tw_idx,
  output logic            compute,
  output logic [SIZE-1:0] stage,
  output logic            finish_FFT,
  output logic            done_all,
  output logic            drop,
  output logic            busy
);

  localparam int DW = $clog2(WR_DLY + 1);
  localparam logic [SIZE-1:0] CNT_LAST   = SIZE'(N - 1);
  localparam logic [SIZE-1:0] STAGE_LAST = SIZE'(SIZE - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(WR_DLY);

  typedef enum logic [2:0] {LOAD, STG_RD, DRAIN, OUT_RD, OUT_END} state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] lc_q, lc_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [SIZE-1:0] stage_q, stage_d;

  logic [WR_DLY-1:0]         wb_vld_q;
  logic [WR_DLY-1:0][SIZE:0] wb_ptr_q;

  logic [SIZE-1:0] lc_rev;
  logic [SIZE-1:0] bf_k, bf_h, bf_p, bf_hi, bf_addr, tw_full;

  // Load address is the load counter mirrored over SIZE bits.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_rev
      assign lc_rev[gi] = lc_q[SIZE-1-gi];
    end
  endgenerate

  // Butterfly k = cnt/2; the a/b select bit (cnt[0]) is inserted at bit position 'stage'.
  always_comb begin
    bf_k    = {1'b0, cnt_q[SIZE-1:1]};
    bf_h    = SIZE'(1) << stage_q;
    bf_p    = bf_k & (bf_h - SIZE'(1));
    bf_hi   = ((bf_k >> stage_q) << stage_q) << 1;
    bf_addr = bf_hi | (cnt_q[0] ? bf_h : '0) | bf_p;
    tw_full = bf_p << (STAGE_LAST - stage_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      lc_q    <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    stage_d = stage_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          lc_d = lc_q + 1'b1;
          if (lc_q == CNT_LAST) begin
            state_d = STG_RD;
            stage_d = '0;
            cnt_d   = '0;
          end
        end
      end
      STG_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DRAIN_LAST) begin
          cnt_d = '0;
          if (stage_q != STAGE_LAST) begin
            stage_d = stage_q + 1'b1;
            state_d = STG_RD;
          end else begin
            state_d = OUT_RD;
          end
        end
      end
      OUT_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = OUT_END;
      end
      OUT_END: begin
        state_d = LOAD;
        lc_d    = '0;
        stage_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    load_data  = 1'b0;
    invert_adr = '0;
    en_rd      = 1'b0;
    rd_ptr     = '0;
    tw_idx     = '0;
    compute    = 1'b0;
    finish_FFT = 1'b0;
    done_all   = 1'b0;
    case (state_q)
      LOAD: begin
        // Gated by rst_n so the strobe is quiet while reset is held.
        load_data  = in_valid & rst_n;
        invert_adr = {1'b0, lc_rev};
      end
      STG_RD: begin
        en_rd   = 1'b1;
        compute = 1'b1;
        rd_ptr  = {1'b0, bf_addr};
        tw_idx  = tw_full[SIZE-2:0];
      end
      OUT_RD: begin
        en_rd      = 1'b1;
        rd_ptr     = {1'b0, cnt_q};
        finish_FFT = (cnt_q == '0);
      end
      OUT_END: done_all = 1'b1;
      default: ;
    endcase
  end

  // Write-back delay line; read-out addresses are never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q <= '0;
      wb_ptr_q <= '0;
    end else begin
      wb_vld_q <= {wb_vld_q[WR_DLY-2:0], compute};
      wb_ptr_q <= {wb_ptr_q[WR_DLY-2:0], (compute ? rd_ptr : {(SIZE+1){1'b0}})};
    end
  end

  assign en_wr  = wb_vld_q[WR_DLY-1];
  assign wr_ptr = wb_ptr_q[WR_DLY-1];
  assign stage  = stage_q;
  assign busy   = (state_q != LOAD);
  assign drop   = in_valid & (state_q != LOAD);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: load order, stage addressing, write-back delay,
// read-out handshake, mid-run reset and ignored in_valid.
module tb_fft_seq_ctrl;
  localparam int N = 16, SIZE = 4, WR_DLY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic            load_data, en_rd, en_wr, compute, finish_FFT, done_all, drop, busy;
  logic [SIZE:0]   invert_adr, rd_ptr, wr_ptr;
  logic [SIZE-2:0] tw_idx;
  logic [SIZE-1:0] stage;

  fft_seq_ctrl #(.N(N), .SIZE(SIZE), .WR_DLY(WR_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .load_data(load_data), .invert_adr(invert_adr),
    .en_rd(en_rd), .rd_ptr(rd_ptr), .en_wr(en_wr), .wr_ptr(wr_ptr),
    .tw_idx(tw_idx), .compute(compute), .stage(stage),
    .finish_FFT(finish_FFT), .done_all(done_all), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int rev_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int s1_tab[8]   = '{0, 2, 1, 3, 4, 6, 5, 7};
  int s3_tab[16]  = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};

  logic [63:0] outs_all;
  assign outs_all = {34'd0, load_data, invert_adr, en_rd, rd_ptr, en_wr, wr_ptr,
                     tw_idx, compute, stage, finish_FFT, done_all, drop, busy};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour c cycles after the last load (c=0 is the first stage read).
  function automatic void model(input int c, output bit erd, output int rp, output bit comp,
                                output int tw, output bit fin, output bit dn, output int stg);
    int s, j, k, h, p, a;
    erd = 0; rp = 0; comp = 0; tw = 0; fin = 0; dn = 0; stg = 0;
    if (c >= 0 && c < SIZE * (N + WR_DLY + 1)) begin
      s = c / (N + WR_DLY + 1);
      j = c % (N + WR_DLY + 1);
      stg = s;
      if (j < N) begin
        k = j / 2;
        h = 1 << s;
        p = k % h;
        a = (k / h) * 2 * h + p;
        erd = 1; comp = 1;
        rp = (j % 2 == 1) ? a + h : a;
        tw = p * ((N / 2) / h);
      end
    end else if (c >= 84 && c < 100) begin
      erd = 1; rp = c - 84; fin = (c == 84); stg = SIZE - 1;
    end else if (c == 100) begin
      dn = 1; stg = SIZE - 1;
    end
  endfunction

  task automatic load_frame();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      chk("load_data", load_data, 1);
      chk("inv_adr", invert_adr, rev_tab[i]);
      chk("busy_ld", busy, 0);
      chk("ld_excl", {en_rd, en_wr}, 0);
    end
  endtask

  task automatic run_frame(input int drop_at, input int last_c);
    bit erd, comp, fin, dn, werd, wcomp, wfin, wdn;
    int rp, tw, stg, wrp, wtw, wstg;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      in_valid = (c == drop_at);
      #1;
      model(c, erd, rp, comp, tw, fin, dn, stg);
      model(c - WR_DLY, werd, wrp, wcomp, wtw, wfin, wdn, wstg);
      chk("en_rd", en_rd, erd);
      if (erd) chk("rd_ptr", rd_ptr, rp);
      chk("compute", compute, comp);
      if (comp) chk("tw_idx", tw_idx, tw);
      chk("en_wr", en_wr, wcomp);
      if (wcomp) chk("wr_ptr", wr_ptr, wrp);
      chk("finish", finish_FFT, fin);
      chk("done_all", done_all, dn);
      chk("busy", busy, (c <= 100));
      chk("drop", drop, (c == drop_at && c <= 100));
      chk("load_x", load_data, 0);
      if (c <= 100) chk("stage", stage, stg);
      if (c >= 21 && c < 29) chk("s1_ptr", rd_ptr, s1_tab[c-21]);
      if (c >= 63 && c < 79) begin
        chk("s3_ptr", rd_ptr, s3_tab[c-63]);
        chk("s3_tw", tw_idx, (c - 63) / 2);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", outs_all, 0);
    rst_n = 1'b1;

    load_frame();
    run_frame(-1, 102);

    // Second frame, interrupted by reset in the middle of stage 2.
    load_frame();
    run_frame(-1, 50);
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs_all, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_wr", en_wr, 0);
      chk("post_rst_busy", busy, 0);
    end

    load_frame();
    run_frame(-1, 102);

    // in_valid while computing must be dropped without disturbing the sequence.
    load_frame();
    run_frame(5, 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencing controller for the in-place radix-2 sequential FFT. It drives the FFT data RAM directly: it generates bit-reversed load addresses while samples arrive, then the per-stage butterfly read/write pointer sequences and twiddle indices. When all stages are done it runs the final read-out with the `finish_FFT`/`done_all` handshake. One read and one write per cycle, single FFT frame in flight.

## Interface
- `N`, 16, FFT length (power of two, ≥4)
- `SIZE`, 4, log2(N); pointer width is SIZE+1 bits, MSB always 0
- `WR_DLY`, 4, cycles from a compute read (`en_rd`) to its write-back (`en_wr`); ≥2

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input sample strobe; sample data goes straight to RAM
- `load_data`  out  1  RAM load strobe
- `invert_adr`  out  SIZE+1  bit-reversed load address
- `en_rd`  out  1  RAM read enable
- `rd_ptr`  out  SIZE+1  RAM read address
- `en_wr`  out  1  RAM write-back enable
- `wr_ptr`  out  SIZE+1  RAM write-back address
- `tw_idx`  out  SIZE-1  twiddle index for the current butterfly
- `compute`  out  1  high while stage reads are issued; downstream butterfly gates the RAM pair strobe with it
- `stage`  out  SIZE  current stage number 0..SIZE-1
- `finish_FFT`  out  1  one-cycle pulse that starts read-out
- `done_all`  out  1  one-cycle pulse that ends read-out
- `drop`  out  1  one-cycle pulse: `in_valid` was ignored
- `busy`  out  1  high in every state except LOAD

## Operation
- FSM states: LOAD (reset state), STG_RD, DRAIN, OUT_RD, OUT_END.
- **LOAD:**
  - `load_data` = `in_valid`, combinational.
  - `invert_adr` = bit-reverse over SIZE bits of the load counter `lc`, combinational.
  - `lc` increments on each `in_valid`.
  - On the N-th sample, go to STG_RD with `stage` = 0.
- **STG_RD:** N consecutive reads, butterfly k = 0..N/2-1, with h = 2^stage:
  - p = k mod h; a = (k/h)·2h + p; b = a + h.
  - Read a, then b, on consecutive cycles.
  - `tw_idx` = p << (SIZE-1-stage); it is valid while reading a and while reading b.
  - `compute` = 1.
  - After the last read, go to DRAIN.
- **Write-back:** a WR_DLY-deep shift register of {compute-read flag, `rd_ptr`}.
  - `en_wr` and `wr_ptr` are its output: same address order, in place.
  - Output-phase reads never enter the shift register.
- **DRAIN:**
  - No reads for WR_DLY+1 cycles. This covers the write-back delay plus the RAM's internal write register.
  - Then, if `stage` < SIZE-1: increment `stage` and go to STG_RD.
  - Otherwise go to OUT_RD.
- **OUT_RD:**
  - `finish_FFT` pulses in its first cycle.
  - Reads `rd_ptr` = 0..N-1 on consecutive cycles, `compute` = 0.
  - Then go to OUT_END.
- **OUT_END:** `done_all` = 1 for one cycle, then go to LOAD with `lc` = 0.
- `in_valid` outside LOAD: ignored, `drop` = 1 in that cycle; the sequence is unaffected.
- **Reset, any time:**
  - All outputs 0; `stage`, `lc` and the shift register cleared.
  - FSM goes to LOAD; no pending write is issued after reset is released.

## Timing
- Reset values: every output 0; `busy` 0.
- `load_data`/`invert_adr` have zero latency from `in_valid`.
- First STG_RD read occurs in the cycle after the N-th load (L = cycle of the last load, read at L+1).
- `en_wr` for a read issued in cycle t occurs in cycle t+WR_DLY.
- Stage period is N + WR_DLY + 1 cycles.
- First read of the next stage comes WR_DLY+2 cycles after the previous stage's last read.
- Output read 0 occurs at L+1+SIZE·(N+WR_DLY+1), in the same cycle as `finish_FFT`.
- Output read N-1 occurs at that cycle + N-1.
- `done_all` comes one cycle after output read N-1, so the RAM's last registered output coincides with it.
- `en_rd` and `en_wr` may be high together (different stage phases); `load_data` is never high together with either.

## Test plan
- **Load (N=16):** 16 `in_valid` pulses → `invert_adr` = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; `busy` rises at L+1.
- **Stage order:**
  - Stage 0: `rd_ptr` = 0,1,2,…,15, `tw_idx` all 0.
  - Stage 1: `rd_ptr` = 0,2,1,3,4,6,5,7…, `tw_idx` = 0,0,4,4,…
  - Stage 3: `rd_ptr` = 0,8,1,9,…,7,15, `tw_idx` = 0,0,1,1,…,7,7.
- **Write-back (WR_DLY=4):** `wr_ptr` equals `rd_ptr` from 4 cycles earlier; `en_rd` is low for exactly 5 cycles between stages; no `en_wr` during OUT_RD.
- **Read-out:** `finish_FFT` at L+85; `rd_ptr` 0..15 over L+85..L+100; `done_all` at L+101; a new frame then loads normally.
- **Reset at stage 2, mid-stage:** assert `rst_n`=0 → all outputs 0 immediately; after release no `en_wr` appears; a full reload and run repeats the cycle counts above.
- **`in_valid` during STG_RD** → `drop` pulses for one cycle; `rd_ptr`, `en_wr` and all cycle counts are unchanged.
